// File: rtl/rf_2p_be_byp_pkg.sv
//------------------------------------------------------------------------------
// rf_2p_be_byp_pkg : state encodings shared by the behavioural memories
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rf_2p_be_byp_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_IDLE  = 1'b1
  } rf_state_t;

  localparam int RF_LANE_BITS = 8;

endpackage

`default_nettype wire

// File: rtl/rf_2p_be_byp_if.sv
//------------------------------------------------------------------------------
// rf_2p_be_byp_if : port A read / port B write bundle with clear control
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface rf_2p_be_byp_if #(
  parameter int Word_Width = 32,
  parameter int Addr_Width = 8
);
  logic                    clr_i;
  logic                    init_done_o;
  logic                    cena_i;
  logic [Addr_Width-1:0]   addra_i;
  logic [Word_Width-1:0]   dataa_o;
  logic                    dataa_vld_o;
  logic                    cenb_i;
  logic [Word_Width/8-1:0] wenb_i;
  logic [Addr_Width-1:0]   addrb_i;
  logic [Word_Width-1:0]   datab_i;

  modport master (
    output clr_i, cena_i, addra_i, cenb_i, wenb_i, addrb_i, datab_i,
    input  init_done_o, dataa_o, dataa_vld_o
  );

  modport slave (
    input  clr_i, cena_i, addra_i, cenb_i, wenb_i, addrb_i, datab_i,
    output init_done_o, dataa_o, dataa_vld_o
  );
endinterface

`default_nettype wire

// File: rtl/rf_be_merge.sv
//------------------------------------------------------------------------------
// rf_be_merge : byte-lane merge, lanes with ben_n=0 take new_word
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rf_be_merge
  import rf_2p_be_byp_pkg::*;
#(
  parameter int Word_Width = 32
) (
  input  logic [Word_Width-1:0]   old_word,
  input  logic [Word_Width-1:0]   new_word,
  input  logic [Word_Width/8-1:0] ben_n,
  output logic [Word_Width-1:0]   merged
);

  for (genvar j = 0; j < Word_Width / RF_LANE_BITS; j++) begin : g_lane
    assign merged[j*RF_LANE_BITS +: RF_LANE_BITS] = ben_n[j]
        ? old_word[j*RF_LANE_BITS +: RF_LANE_BITS]
        : new_word[j*RF_LANE_BITS +: RF_LANE_BITS];
  end

endmodule

`default_nettype wire

// File: rtl/rf_2p_be_byp.sv
//------------------------------------------------------------------------------
// rf_2p_be_byp : 2-port byte-enable register file, clear sweep, RAW bypass
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rf_2p_be_byp
  import rf_2p_be_byp_pkg::*;
#(
  parameter int         Word_Width = 32,
  parameter int         Addr_Width = 8,
  parameter int         RD_LAT     = 1,
  parameter int         BYPASS     = 1,
  parameter logic [7:0] CLR_VAL    = 8'h00
) (
  input  logic         clk,
  input  logic         rst,
  rf_2p_be_byp_if.slave bus
);

  localparam int Byte_Width = Word_Width >> 3;
  localparam int DEPTH      = 1 << Addr_Width;
  localparam logic [Addr_Width-1:0] LAST_ADDR = Addr_Width'(DEPTH - 1);
  localparam logic [Word_Width-1:0] CLR_WORD  = {Byte_Width{CLR_VAL}};

  rf_state_t             state, state_nxt;
  logic [Addr_Width-1:0] cnt;
  logic                  init_done;
  logic [Word_Width-1:0] mem [DEPTH];

  logic                  idle, wr_en, rd_en, collide;
  logic [Word_Width-1:0] wr_old, rd_old, wr_word, byp_word, rd_word;
  logic                  rd1_vld;
  logic [Word_Width-1:0] rd1_data;

  assign idle    = (state == RF_IDLE);
  assign wr_en   = idle && !bus.cenb_i && !(&bus.wenb_i);
  assign rd_en   = idle && !bus.cena_i;
  assign collide = wr_en && (bus.addra_i == bus.addrb_i);
  assign wr_old  = mem[bus.addrb_i];
  assign rd_old  = mem[bus.addra_i];

  rf_be_merge #(.Word_Width(Word_Width)) u_wr_merge (
    .old_word (wr_old),
    .new_word (bus.datab_i),
    .ben_n    (bus.wenb_i),
    .merged   (wr_word)
  );

  rf_be_merge #(.Word_Width(Word_Width)) u_byp_merge (
    .old_word (rd_old),
    .new_word (bus.datab_i),
    .ben_n    (bus.wenb_i),
    .merged   (byp_word)
  );

  // Write-first forwarding only when configured; otherwise old data wins.
  assign rd_word = ((BYPASS != 0) && collide) ? byp_word : rd_old;

  always_comb begin
    state_nxt = state;
    case (state)
      RF_CLEAR: if (cnt == LAST_ADDR) state_nxt = RF_IDLE;
      RF_IDLE:  if (bus.clr_i)        state_nxt = RF_CLEAR;
      default:  state_nxt = RF_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RF_CLEAR;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_done <= (state_nxt == RF_IDLE);
      if (state == RF_CLEAR) cnt <= cnt + Addr_Width'(1);
      else if (bus.clr_i)    cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == RF_CLEAR) mem[cnt] <= CLR_WORD;
    else if (wr_en)        mem[bus.addrb_i] <= wr_word;
  end

  // Data registers only load on a valid read, so the output holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_vld  <= 1'b0;
      rd1_data <= '0;
    end else begin
      rd1_vld <= rd_en;
      if (rd_en) rd1_data <= rd_word;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic                  rd2_vld;
    logic [Word_Width-1:0] rd2_data;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd2_vld  <= 1'b0;
        rd2_data <= '0;
      end else begin
        rd2_vld <= rd1_vld;
        if (rd1_vld) rd2_data <= rd1_data;
      end
    end

    assign bus.dataa_o     = rd2_data;
    assign bus.dataa_vld_o = rd2_vld;
  end else begin : g_lat1
    assign bus.dataa_o     = rd1_data;
    assign bus.dataa_vld_o = rd1_vld;
  end

  assign bus.init_done_o = init_done;

endmodule

`default_nettype wire

// File: tb/tb_rf_2p_be_byp.sv
//------------------------------------------------------------------------------
// tb_rf_2p_be_byp : directed bench over three configurations of rf_2p_be_byp
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rf_2p_be_byp;

  logic        clk;
  logic        rst;
  logic        clr, cena, cenb;
  logic [3:0]  addra, addrb, wenb;
  logic [31:0] datab;
  int          tests;
  int          failed;

  rf_2p_be_byp_if #(.Word_Width(32), .Addr_Width(4)) ifa ();
  rf_2p_be_byp_if #(.Word_Width(32), .Addr_Width(4)) ifb ();
  rf_2p_be_byp_if #(.Word_Width(32), .Addr_Width(4)) ifc ();

  assign ifa.clr_i = clr;   assign ifb.clr_i = clr;   assign ifc.clr_i = clr;
  assign ifa.cena_i = cena; assign ifb.cena_i = cena; assign ifc.cena_i = cena;
  assign ifa.addra_i = addra; assign ifb.addra_i = addra; assign ifc.addra_i = addra;
  assign ifa.cenb_i = cenb; assign ifb.cenb_i = cenb; assign ifc.cenb_i = cenb;
  assign ifa.wenb_i = wenb; assign ifb.wenb_i = wenb; assign ifc.wenb_i = wenb;
  assign ifa.addrb_i = addrb; assign ifb.addrb_i = addrb; assign ifc.addrb_i = addrb;
  assign ifa.datab_i = datab; assign ifb.datab_i = datab; assign ifc.datab_i = datab;

  rf_2p_be_byp #(.Word_Width(32), .Addr_Width(4), .RD_LAT(1), .BYPASS(1), .CLR_VAL(8'h00))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  rf_2p_be_byp #(.Word_Width(32), .Addr_Width(4), .RD_LAT(1), .BYPASS(0), .CLR_VAL(8'h00))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  rf_2p_be_byp #(.Word_Width(32), .Addr_Width(4), .RD_LAT(2), .BYPASS(1), .CLR_VAL(8'h00))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        cena;
    logic [3:0]  addra;
    logic        cenb;
    logic [3:0]  wenb;
    logic [3:0]  addrb;
    logic [31:0] datab;
    logic        exp_vld;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ca, input logic [3:0] aa, input logic cb,
                       input logic [3:0] wb, input logic [3:0] ab, input logic [31:0] db);
    cena = ca; addra = aa; cenb = cb; wenb = wb; addrb = ab; datab = db;
  endtask

  task automatic add(input logic ca, input logic [3:0] aa, input logic cb,
                     input logic [3:0] wb, input logic [3:0] ab, input logic [31:0] db,
                     input logic ev, input logic [31:0] ea, input logic [31:0] eb);
    vec_t v;
    v.cena = ca; v.addra = aa; v.cenb = cb; v.wenb = wb; v.addrb = ab; v.datab = db;
    v.exp_vld = ev; v.exp_a = ea; v.exp_b = eb;
    vecs.push_back(v);
  endtask

  task automatic sweep_wait(input string nm);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk(nm, {31'd0, ifa.init_done_o}, {31'd0, k == 16});
    end
  endtask

  initial begin
    logic        prev_vld;
    logic [31:0] prev_data;
    tests = 0;
    failed = 0;
    rst = 1'b1;
    clr = 1'b0;
    drive(1'b1, 4'd0, 1'b1, 4'hF, 4'd0, 32'd0);

    // table: write merge, collisions, no-op writes
    add(1, 4'd0,  0, 4'b0000, 4'd5,  32'hAABBCCDD, 0, 32'h0,        32'h0);
    add(1, 4'd0,  0, 4'b1010, 4'd5,  32'h11223344, 0, 32'h0,        32'h0);
    add(0, 4'd5,  1, 4'b1111, 4'd0,  32'h0,        1, 32'hAA22CC44, 32'hAA22CC44);
    add(1, 4'd0,  1, 4'b1111, 4'd0,  32'h0,        0, 32'hAA22CC44, 32'hAA22CC44);
    add(0, 4'd3,  0, 4'b1100, 4'd3,  32'hDEADBEEF, 1, 32'h0000BEEF, 32'h00000000);
    add(0, 4'd3,  1, 4'b1111, 4'd0,  32'h0,        1, 32'h0000BEEF, 32'h0000BEEF);
    add(0, 4'd3,  0, 4'b1111, 4'd3,  32'hFFFFFFFF, 1, 32'h0000BEEF, 32'h0000BEEF);
    add(0, 4'd15, 1, 4'b0000, 4'd15, 32'h12345678, 1, 32'h0,        32'h0);
    add(0, 4'd15, 1, 4'b1111, 4'd0,  32'h0,        1, 32'h0,        32'h0);
    add(1, 4'd0,  0, 4'b0000, 4'd0,  32'h01020304, 0, 32'h0,        32'h0);
    add(1, 4'd0,  0, 4'b0000, 4'd1,  32'hA1A2A3A4, 0, 32'h0,        32'h0);
    add(0, 4'd1,  0, 4'b0000, 4'd2,  32'hC1C2C3C4, 1, 32'hA1A2A3A4, 32'hA1A2A3A4);
    add(1, 4'd0,  1, 4'b1111, 4'd0,  32'h0,        0, 32'hA1A2A3A4, 32'hA1A2A3A4);

    // reset state and initial sweep
    tick(); tick();
    chk("rst init_done", {31'd0, ifa.init_done_o}, 32'd0);
    chk("rst dataa", ifa.dataa_o, 32'd0);
    chk("rst vld", {31'd0, ifa.dataa_vld_o}, 32'd0);
    chk("rst dataa lat2", ifc.dataa_o, 32'd0);
    rst = 1'b0;
    sweep_wait("init sweep done");
    chk("init_done b", {31'd0, ifb.init_done_o}, 32'd1);

    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'(i), 1'b1, 4'hF, 4'd0, 32'd0);
      tick();
      chk("cleared rd vld", {31'd0, ifa.dataa_vld_o}, 32'd1);
      chk("cleared rd data", ifa.dataa_o, 32'd0);
    end
    drive(1'b1, 4'd0, 1'b1, 4'hF, 4'd0, 32'd0);
    tick(); tick();

    prev_vld = 1'b0;
    prev_data = 32'd0;
    foreach (vecs[i]) begin
      drive(vecs[i].cena, vecs[i].addra, vecs[i].cenb, vecs[i].wenb, vecs[i].addrb, vecs[i].datab);
      tick();
      chk($sformatf("vec%0d vld", i), {31'd0, ifa.dataa_vld_o}, {31'd0, vecs[i].exp_vld});
      chk($sformatf("vec%0d data byp", i), ifa.dataa_o, vecs[i].exp_a);
      chk($sformatf("vec%0d data nobyp", i), ifb.dataa_o, vecs[i].exp_b);
      chk($sformatf("vec%0d lat2 vld", i), {31'd0, ifc.dataa_vld_o}, {31'd0, prev_vld});
      chk($sformatf("vec%0d lat2 data", i), ifc.dataa_o, prev_data);
      prev_vld = vecs[i].exp_vld;
      prev_data = vecs[i].exp_a;
    end
    drive(1'b1, 4'd0, 1'b1, 4'hF, 4'd0, 32'd0);
    tick();

    // two-cycle latency streaming
    drive(1'b0, 4'd0, 1'b1, 4'hF, 4'd0, 32'd0); tick();
    chk("lat2 t+1 vld", {31'd0, ifc.dataa_vld_o}, 32'd0);
    drive(1'b0, 4'd1, 1'b1, 4'hF, 4'd0, 32'd0); tick();
    chk("lat2 t+2 vld", {31'd0, ifc.dataa_vld_o}, 32'd1);
    chk("lat2 t+2 data", ifc.dataa_o, 32'h01020304);
    drive(1'b0, 4'd2, 1'b1, 4'hF, 4'd0, 32'd0); tick();
    chk("lat2 t+3 vld", {31'd0, ifc.dataa_vld_o}, 32'd1);
    chk("lat2 t+3 data", ifc.dataa_o, 32'hA1A2A3A4);
    drive(1'b1, 4'd0, 1'b1, 4'hF, 4'd0, 32'd0); tick();
    chk("lat2 t+4 vld", {31'd0, ifc.dataa_vld_o}, 32'd1);
    chk("lat2 t+4 data", ifc.dataa_o, 32'hC1C2C3C4);
    tick();
    chk("lat2 hold vld", {31'd0, ifc.dataa_vld_o}, 32'd0);
    chk("lat2 hold data", ifc.dataa_o, 32'hC1C2C3C4);

    // fill, then clear with a coincident write
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'd0, 1'b0, 4'b0000, 4'(i), 32'h01010101 * i);
      tick();
    end
    clr = 1'b1;
    drive(1'b1, 4'd0, 1'b0, 4'b0000, 4'd7, 32'h77777777);
    tick();
    clr = 1'b0;
    chk("clr init_done fall", {31'd0, ifa.init_done_o}, 32'd0);
    chk("clr-cycle write commit", dut_a.mem[7], 32'h77777777);
    drive(1'b0, 4'd9, 1'b0, 4'b0000, 4'd9, 32'h99999999);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("sweep vld suppressed", {31'd0, ifa.dataa_vld_o}, 32'd0);
      chk("sweep data hold", ifa.dataa_o, 32'hC1C2C3C4);
      chk("sweep init_done", {31'd0, ifa.init_done_o}, {31'd0, k == 16});
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'(i), 1'b1, 4'hF, 4'd0, 32'd0);
      tick();
      chk("post-clr vld", {31'd0, ifa.dataa_vld_o}, 32'd1);
      chk("post-clr data", ifa.dataa_o, 32'd0);
      chk("post-clr data nobyp", ifb.dataa_o, 32'd0);
    end

    // reset in the middle of a sweep
    drive(1'b1, 4'd0, 1'b0, 4'b0000, 4'd4, 32'h5A5A5A5A); tick();
    drive(1'b0, 4'd4, 1'b1, 4'hF, 4'd0, 32'd0); tick();
    chk("pre-rst read", ifa.dataa_o, 32'h5A5A5A5A);
    drive(1'b1, 4'd0, 1'b1, 4'hF, 4'd0, 32'd0);
    clr = 1'b1; tick(); clr = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    rst = 1'b1;
    #1;
    chk("mid-sweep rst init_done", {31'd0, ifa.init_done_o}, 32'd0);
    chk("mid-sweep rst data", ifa.dataa_o, 32'd0);
    chk("mid-sweep rst lat2 data", ifc.dataa_o, 32'd0);
    tick(); tick();
    chk("rst held init_done", {31'd0, ifc.init_done_o}, 32'd0);
    rst = 1'b0;
    sweep_wait("restart sweep done");
    drive(1'b0, 4'd4, 1'b1, 4'hF, 4'd0, 32'd0); tick();
    chk("restart cleared addr4", ifa.dataa_o, 32'd0);
    chk("restart cleared vld", {31'd0, ifa.dataa_vld_o}, 32'd1);
    drive(1'b1, 4'd0, 1'b1, 4'hF, 4'd0, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_2p_be_byp.md
Name: rf_2p_be_byp

Overview:
Single-clock two-port register file with per-byte write enable. It adds a hardware clear sweep, same-address read-during-write forwarding, a selectable 1- or 2-cycle read latency, and a read-valid strobe. It is a parametrised successor used for encoder line buffers and coefficient stores, where memory contents must be known after reset and read-after-write hazards must resolve in hardware.

Parameters:
Word_Width, 32, data width in bits; must be a multiple of 8.
Addr_Width, 8, address width; depth = 1<<Addr_Width.
Byte_Width, Word_Width>>3, number of byte lanes (derived; do not override).
RD_LAT, 1, read latency in cycles; legal values are 1 and 2.
BYPASS, 1, 1 = write-first forwarding on same-address collision; 0 = read-first (old data).
CLR_VAL, 0, byte value written to every byte lane during a clear sweep.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  asynchronous reset, active-high.
clr_i  input  1  clear request pulse; sampled only when init_done_o=1.
init_done_o  output  1  1 = clear sweep finished and ports are live.
cena_i  input  1  port A read enable, low active.
addra_i  input  Addr_Width  port A read address.
dataa_o  output  Word_Width  port A read data.
dataa_vld_o  output  1  dataa_o is valid this cycle.
cenb_i  input  1  port B write enable, low active.
wenb_i  input  Byte_Width  per-byte write enable, low active.
addrb_i  input  Addr_Width  port B write address.
datab_i  input  Word_Width  port B write data.

Behaviour:
- Reset values: dataa_o=0, dataa_vld_o=0, init_done_o=0, FSM=CLEAR, sweep counter=0, pipeline valids=0. Memory array is not reset.
- FSM states:
  - CLEAR: writes CLR_VAL replicated to every byte of mem[cnt]; cnt increments by 1 per cycle. On cnt==depth-1 the FSM moves to IDLE. A sweep takes exactly depth cycles.
  - IDLE: init_done_o=1. If clr_i=1, the FSM returns to CLEAR with cnt=0 on the next edge, and any port B write in that same cycle is still committed.
- init_done_o is registered. It rises on the edge that completes the final clear write, and falls on the edge that enters CLEAR.
- While in CLEAR, port A and port B requests are ignored: no write occurs and no valid is issued. Reads already in the pipeline complete with their captured data.
- Write: occurs when IDLE, cenb_i=0 and wenb_i is not all ones. Each byte j of mem[addrb_i] takes datab_i byte j where wenb_i[j]=0; all other bytes are kept.
- Read (IDLE, cena_i=0):
  - Array access is registered.
  - RD_LAT=1: data and valid appear on the next edge.
  - RD_LAT=2: one extra output register stage is added.
  - dataa_vld_o pulses with each datum, so back-to-back reads give one result per cycle.
- cena_i=1: dataa_o holds its last value and dataa_vld_o=0. The output never goes to X.
- Collision (read and write to the same address in the same cycle):
  - BYPASS=1: the read returns the merged word. Written bytes come from datab_i; unwritten bytes come from the old mem content.
  - BYPASS=0: the read returns the old word.
- Address wrap is not applicable: addresses are full-range.
- Reset asserted mid-sweep or mid-read: everything returns to reset values immediately, and the sweep restarts from address 0 after rst falls.

Decomposition:
- The shared include holds the state encodings RF_CLEAR=1'b0 and RF_IDLE=1'b1. It is shared with the other behavioural memories in lib/behave/mem.
- One sub-module, rf_be_merge: purely combinational byte-lane merge (old word, new word, active-low byte enables → merged word). It is instantiated twice: once for the write path and once for the bypass path.
- The FSM, counter and read pipeline stay in the top module.

Test Plan:
1. Reset, Addr_Width=4 → init_done_o=0 for 16 cycles then 1; reads of addresses 0..15 return 32'h00000000 with dataa_vld_o=1 one cycle after each request (RD_LAT=1).
2. Write addr 5 = 32'hAABBCCDD with wenb_i=4'b0000; then write addr 5 = 32'h11223344 with wenb_i=4'b1010; read addr 5 → 32'hAA22CC44.
3. BYPASS=1, mem[3]=32'h0; in the same cycle write addr 3 = 32'hDEADBEEF with wenb_i=4'b1100 and read addr 3 → 32'h0000BEEF. Repeat with BYPASS=0 → 32'h00000000; a later read → 32'h0000BEEF.
4. RD_LAT=2: continuous reads of addresses 0,1,2 starting at cycle t → data at t+2, t+3, t+4 with dataa_vld_o high for 3 cycles. Then cena_i=1 → dataa_o holds its last value and dataa_vld_o=0.
5. After filling memory, pulse clr_i with a simultaneous write to addr 7 → that write commits, then the sweep runs 16 cycles with writes and reads ignored; afterwards every address reads 0.
6. Assert rst at sweep cycle 6 → init_done_o stays 0; after release a full 16-cycle sweep restarts, and init_done_o=1 exactly 16 cycles after rst falls.
